mux4_rr_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for the 4:1 mux datapath (mux_4to1_using_2to1).

---
 rtl/mux4_rr_arbiter.sv | 114 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one valid/ready output channel.
// Grants are held for at most MAX_BURST beats, then priority rotates past the winner.
module mux4_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic [3:0]        in_ready,
  output logic [3:0]        grant,
  output logic [1:0]        sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nx;
  logic [3:0]      grant_nx;
  logic [1:0]      sel_nx, ptr, ptr_nx;
  logic [CW-1:0]   beat_cnt, cnt_nx;
  logic [2:0]      pick_idle, pick_rel;
  logic            xfer, last_beat, release_g;
  logic [DATA_W-1:0] mux_lo, mux_hi;

  // Returns {found, index}; search starts at p and wraps, lowest offset wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign busy      = (state == GRANT);
  assign out_valid = busy & req[sel];
  assign in_ready  = grant & {4{out_ready}};
  assign xfer      = out_valid & out_ready;
  assign last_beat = (beat_cnt == CW'(MAX_BURST - 1));
  assign release_g = (xfer & last_beat) | ~req[sel];

  assign mux_lo   = sel[0] ? in_data1 : in_data0;
  assign mux_hi   = sel[0] ? in_data3 : in_data2;
  assign out_data = sel[1] ? mux_hi : mux_lo;

  // The released requester sits last in the new search order.
  assign pick_idle = rr_pick(req, ptr);
  assign pick_rel  = rr_pick(req, sel + 2'd1);

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    sel_nx   = sel;
    ptr_nx   = ptr;
    cnt_nx   = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_idle[2]) begin
          state_nx = GRANT;
          grant_nx = 4'b0001 << pick_idle[1:0];
          sel_nx   = pick_idle[1:0];
          cnt_nx   = '0;
        end
      end
      GRANT: begin
        if (xfer) cnt_nx = beat_cnt + CW'(1);
        if (release_g) begin
          ptr_nx = sel + 2'd1;
          cnt_nx = '0;
          if (pick_rel[2]) begin
            grant_nx = 4'b0001 << pick_rel[1:0];
            sel_nx   = pick_rel[1:0];
          end else begin
            state_nx = IDLE;
            grant_nx = '0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      sel      <= sel_nx;
      ptr      <= ptr_nx;
      beat_cnt <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, single grant, rotation, backpressure,
// request drop, lone re-grant and mid-burst reset.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready, grant;
  logic [1:0] sel;
  logic       out_valid, out_ready, busy;
  logic [7:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  mux4_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_ready(in_ready), .grant(grant), .sel(sel), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'h0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] eg;
    rst_n = 1'b0; req = 4'hF; out_ready = 1'b1;
    in_data0 = 8'h10; in_data1 = 8'h11; in_data2 = 8'h12; in_data3 = 8'h13;

    // 1: reset held with all requesting
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_inready", 32'(in_ready), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end

    // 2: single requester 2
    rst_n = 1'b1; req = 4'b0100; in_data2 = 8'hA5;
    step();
    chk("t2_grant", 32'(grant), 32'h4);
    chk("t2_sel", 32'(sel), 32'h2);
    chk("t2_data", 32'(out_data), 32'hA5);
    chk("t2_inready", 32'(in_ready), 32'h4);
    chk("t2_valid", 32'(out_valid), 32'h1);

    // 3: all requesting, 4-beat rotation with no gap
    in_data2 = 8'h12;
    do_reset();
    req = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      eg = 4'b0001 << ((c / 4) % 4);
      chk("t3_grant", 32'(grant), 32'(eg));
      chk("t3_sel", 32'(sel), 32'((c / 4) % 4));
      chk("t3_data", 32'(out_data), 32'(8'h10 + ((c / 4) % 4)));
    end

    // 4: backpressure on requester 1, then 4 beats and rotation to 2
    do_reset();
    req = 4'b0110; out_ready = 1'b0;
    step();
    chk("t4_grant0", 32'(grant), 32'h2);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t4_hold_grant", 32'(grant), 32'h2);
      chk("t4_hold_inready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("t4_inready", 32'(in_ready), 32'h2);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t4_burst_grant", 32'(grant), 32'h2);
    end
    step();
    chk("t4_rot_grant", 32'(grant), 32'h4);
    chk("t4_rot_sel", 32'(sel), 32'h2);

    // 5: requester 1 drops after 2 beats
    do_reset();
    req = 4'b1010; out_ready = 1'b1;
    step();
    chk("t5_grant1", 32'(grant), 32'h2);
    step();
    step();
    chk("t5_grant1b", 32'(grant), 32'h2);
    req = 4'b1000;
    step();
    chk("t5_grant3", 32'(grant), 32'h8);
    chk("t5_sel3", 32'(sel), 32'h3);
    chk("t5_ptr", 32'(dut.ptr), 32'h2);
    req = 4'b0000;
    step();
    chk("t5_idle_grant", 32'(grant), 32'h0);
    chk("t5_idle_busy", 32'(busy), 32'h0);

    // lone requester re-granted back-to-back after its burst
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      step();
      chk("lone_grant", 32'(grant), 32'h1);
    end

    // 6: reset mid-burst on requester 2
    do_reset();
    req = 4'b0100; out_ready = 1'b1;
    step();
    chk("t6_grant2", 32'(grant), 32'h4);
    step();
    rst_n = 1'b0;
    step();
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1; req = 4'hF;
    step();
    chk("t6_regrant", 32'(grant), 32'h1);
    chk("t6_sel", 32'(sel), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
